// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Arbitrates the completing execution units (integer, multiplier, divider,
// load/store) onto the single Common Data Bus. A round-robin search picks at
// most one requester per cycle. The winner's tag, result and destination
// register are registered and broadcast for exactly one cycle. cdb_valid and
// cdb_tag also act as the tag-return port of the tag free-list.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   flush        synchronous squash of arbitration and the pending broadcast
//   req_valid    per-unit result-ready request
//   req_tag      flattened tags, unit i at [i*TAG_WIDTH +: TAG_WIDTH]
//   req_data     flattened results, same packing
//   req_rd_addr  flattened destination register indexes, same packing
//   grant        one-hot (or zero) acceptance, combinational
//   cdb_valid    broadcast valid (registered)
//   cdb_tag      broadcast tag (registered)
//   cdb_data     broadcast result (registered)
//   cdb_rd_addr  broadcast destination register (registered)
//   cdb_src      index of the unit owning the current broadcast (registered)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TAG_WIDTH      = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    localparam int PTR_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              flush,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]      req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_rd_addr,
    output logic [NUM_REQ-1:0]                grant,
    output logic                              cdb_valid,
    output logic [TAG_WIDTH-1:0]              cdb_tag,
    output logic [DATA_WIDTH-1:0]             cdb_data,
    output logic [REG_ADDR_WIDTH-1:0]         cdb_rd_addr,
    output logic [PTR_WIDTH-1:0]              cdb_src
);

    logic [PTR_WIDTH-1:0] ptr;
    logic [PTR_WIDTH-1:0] win_idx;
    logic [PTR_WIDTH-1:0] next_ptr;
    logic                 found;
    logic                 accept;
    int                   idx;

    // Round-robin search starting at ptr. The wrap is an explicit subtract
    // rather than natural overflow so that non-power-of-2 NUM_REQ never
    // produces an out-of-range index.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = PTR_WIDTH'(idx);
            end
        end
    end

    // No grant during reset or flush; otherwise the search winner.
    always_comb begin
        grant  = '0;
        accept = found && i_rst_n && !flush;
        if (accept) begin
            grant[win_idx] = 1'b1;
        end
    end

    // Pointer moves to the slot just after the winner, wrapping by compare.
    always_comb begin
        if (win_idx == PTR_WIDTH'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win_idx + 1'b1;
        end
    end

    // Broadcast register: capture the winner's payload, otherwise clear the
    // payload so an idle bus never shows stale data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr         <= '0;
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_rd_addr <= '0;
            cdb_src     <= '0;
        end else if (flush) begin
            ptr         <= '0;
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_rd_addr <= '0;
            cdb_src     <= '0;
        end else if (accept) begin
            ptr         <= next_ptr;
            cdb_valid   <= 1'b1;
            cdb_tag     <= req_tag[win_idx*TAG_WIDTH +: TAG_WIDTH];
            cdb_data    <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
            cdb_rd_addr <= req_rd_addr[win_idx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            cdb_src     <= win_idx;
        end else begin
            cdb_valid   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_rd_addr <= '0;
            cdb_src     <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. A four-unit instance exercises reset,
// single requests, pointer wrap, flush and full round-robin rotation; a
// three-unit instance checks non-power-of-2 wrap and asynchronous reset.
// Expected broadcasts are queued when a grant is expected and compared one
// cycle later against the bus.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    typedef struct {
        logic        v;
        logic [5:0]  tag;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  src;
    } bcast_t;

    logic        clk = 1'b0;
    logic        rst_n4 = 1'b0;
    logic        rst_n3 = 1'b0;
    logic        flush4 = 1'b0;
    logic        flush3 = 1'b0;

    logic [3:0]  req4 = '0;
    logic [23:0] tag4;
    logic [127:0] data4;
    logic [19:0] rd4;
    logic [3:0]  grant4;
    logic        cv4;
    logic [5:0]  ct4;
    logic [31:0] cd4;
    logic [4:0]  cr4;
    logic [1:0]  cs4;

    logic [2:0]  req3 = '0;
    logic [17:0] tag3;
    logic [95:0] data3;
    logic [14:0] rd3;
    logic [2:0]  grant3;
    logic        cv3;
    logic [5:0]  ct3;
    logic [31:0] cd3;
    logic [4:0]  cr3;
    logic [1:0]  cs3;

    logic [5:0]  tagv [4];
    logic [31:0] datav [4];
    logic [4:0]  rdv [4];

    bcast_t      sb [$];
    logic        exp3_v = 1'b0;
    logic [1:0]  exp3_src = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Per-unit payloads; unit 1 carries the values from the single-request case.
    initial begin
        for (int i = 0; i < 4; i++) begin
            tagv[i]  = 6'(8 + i);
            datav[i] = 32'hA000_0000 + 32'(i);
            rdv[i]   = 5'(16 + i);
        end
        tagv[1]  = 6'd5;
        datav[1] = 32'hDEADBEEF;
        rdv[1]   = 5'd3;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tag4[i*6 +: 6]   = tagv[i];
            data4[i*32 +: 32] = datav[i];
            rd4[i*5 +: 5]    = rdv[i];
        end
        for (int i = 0; i < 3; i++) begin
            tag3[i*6 +: 6]   = tagv[i];
            data3[i*32 +: 32] = datav[i];
            rd3[i*5 +: 5]    = rdv[i];
        end
    end

    cdb_arbiter #(.NUM_REQ(4), .TAG_WIDTH(6), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n4), .flush(flush4),
        .req_valid(req4), .req_tag(tag4), .req_data(data4), .req_rd_addr(rd4),
        .grant(grant4), .cdb_valid(cv4), .cdb_tag(ct4), .cdb_data(cd4),
        .cdb_rd_addr(cr4), .cdb_src(cs4)
    );

    cdb_arbiter #(.NUM_REQ(3), .TAG_WIDTH(6), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n3), .flush(flush3),
        .req_valid(req3), .req_tag(tag3), .req_data(data3), .req_rd_addr(rd3),
        .grant(grant3), .cdb_valid(cv3), .cdb_tag(ct3), .cdb_data(cd3),
        .cdb_rd_addr(cr3), .cdb_src(cs3)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: at the falling edge compare the bus against the queued
    // expectation and the grants against the given constants, queue the
    // broadcast implied by the expected grant, then advance past the rising edge.
    task automatic tick(input logic [3:0] eg4, input logic [2:0] eg3);
        bcast_t e;
        bcast_t n;
        @(negedge clk);
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=%0d", sb.size(), 1);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cdb_valid", 64'(cv4), 64'(e.v));
            chk("cdb_tag", 64'(ct4), 64'(e.tag));
            chk("cdb_data", 64'(cd4), 64'(e.data));
            chk("cdb_rd_addr", 64'(cr4), 64'(e.rd));
            chk("cdb_src", 64'(cs4), 64'(e.src));
        end
        chk("grant4", 64'(grant4), 64'(eg4));
        chk("grant3", 64'(grant3), 64'(eg3));
        chk("cdb_valid3", 64'(cv3), 64'(exp3_v));
        chk("cdb_src3", 64'(cs3), 64'(exp3_src));
        n.v = 1'b0; n.tag = '0; n.data = '0; n.rd = '0; n.src = '0;
        for (int i = 0; i < 4; i++) begin
            if (eg4[i]) begin
                n.v = 1'b1; n.tag = tagv[i]; n.data = datav[i];
                n.rd = rdv[i]; n.src = 2'(i);
            end
        end
        sb.push_back(n);
        exp3_v   = (eg3 != 3'b000);
        exp3_src = '0;
        for (int i = 0; i < 3; i++) begin
            if (eg3[i]) exp3_src = 2'(i);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with every unit requesting: no grant, bus cleared.
        req4 = 4'b1111;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_grant", 64'(grant4), 64'h0);
        chk("reset_valid", 64'(cv4), 64'h0);
        chk("reset_payload", {ct4, cd4, cr4, cs4}, 64'h0);
        chk("reset_grant3", 64'(grant3), 64'h0);
        rst_n4 = 1'b1;
        rst_n3 = 1'b1;
        sb.push_back('{v: 1'b0, tag: 6'd0, data: 32'd0, rd: 5'd0, src: 2'd0});
        tick(4'b0001, 3'b000);

        // Single request from unit 1, then the bus goes idle and zeroed.
        req4 = 4'b0010;
        tick(4'b0010, 3'b000);
        req4 = 4'b0000;
        tick(4'b0000, 3'b000);
        tick(4'b0000, 3'b000);

        // ptr=2: unit 3 wins before unit 0, no idle cycle between them.
        req4 = 4'b1001;
        tick(4'b1000, 3'b000);
        req4 = 4'b0001;
        tick(4'b0001, 3'b000);

        // Flush while unit 0's broadcast is on the bus and unit 2 requests.
        req4 = 4'b0100;
        flush4 = 1'b1;
        tick(4'b0000, 3'b000);
        flush4 = 1'b0;
        req4 = 4'b0101;
        tick(4'b0001, 3'b000);
        req4 = 4'b0100;
        tick(4'b0100, 3'b000);

        // Flush restores ptr=0, then full rotation with everyone requesting.
        req4 = 4'b0000;
        flush4 = 1'b1;
        tick(4'b0000, 3'b000);
        flush4 = 1'b0;
        req4 = 4'b1111;
        tick(4'b0001, 3'b000);
        tick(4'b0010, 3'b000);
        tick(4'b0100, 3'b000);
        tick(4'b1000, 3'b000);
        tick(4'b0001, 3'b000);
        tick(4'b0010, 3'b000);
        req4 = 4'b0000;
        tick(4'b0000, 3'b000);
        tick(4'b0000, 3'b000);

        // Three-unit instance: wrap from 2 back to 0.
        req3 = 3'b111;
        tick(4'b0000, 3'b001);
        tick(4'b0000, 3'b010);
        tick(4'b0000, 3'b100);
        tick(4'b0000, 3'b001);

        // Asynchronous reset mid-stream clears the bus before the next edge.
        chk("pre_reset_valid3", 64'(cv3), 64'h1);
        rst_n3 = 1'b0;
        #1;
        chk("async_reset_valid3", 64'(cv3), 64'h0);
        chk("async_reset_payload3", {ct3, cd3, cr3, cs3}, 64'h0);
        chk("async_reset_grant3", 64'(grant3), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates completing execution units (integer, multiplier, divider, load/store) onto the single Common Data Bus.
- Drives the one registered CDB broadcast per cycle: tag, data and destination register.
- Is the writer side of the tag free-list. cdb_valid/cdb_tag feed the free-list tag-return inputs directly and also go to the reservation stations and register status table.
- Uses round-robin arbitration so no unit starves; flush discards in-flight broadcasts.

Parameters:
- NUM_REQ, 4, number of requesting execution units (>=2, need not be a power of 2)
- TAG_WIDTH, 6, tag width; matches free-list DATA_WIDTH
- DATA_WIDTH, 32, result width
- REG_ADDR_WIDTH, 5, destination architectural register index width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- flush  in  1  synchronous squash of arbitration and pending broadcast
- req_valid  in  NUM_REQ  per-unit result-ready request
- req_tag  in  NUM_REQ*TAG_WIDTH  flattened tags; unit i at [i*TAG_WIDTH +: TAG_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  flattened results, same packing
- req_rd_addr  in  NUM_REQ*REG_ADDR_WIDTH  flattened destination indexes, same packing
- grant  out  NUM_REQ  one-hot (or zero) acceptance, combinational
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_WIDTH  broadcast tag (registered)
- cdb_data  out  DATA_WIDTH  broadcast result (registered)
- cdb_rd_addr  out  REG_ADDR_WIDTH  broadcast destination (registered)
- cdb_src  out  $clog2(NUM_REQ)  index of the unit that owns the current broadcast (registered)

Behaviour:
- Reset: the interface reset is i_rst_n, asynchronous, active-low; the clock is i_clk.
  - On assertion: cdb_valid=0, cdb_tag/cdb_data/cdb_rd_addr/cdb_src=0, round-robin pointer ptr=0.
  - grant=0 while i_rst_n=0.
- Handshake:
  - A unit raises req_valid[i] with its payload held stable until the cycle grant[i]=1.
  - Transfer occurs at the clock edge where req_valid[i]&grant[i]. The unit may drop or present a new request the following cycle.
  - A unit must not withdraw req_valid before it is granted; the arbiter does not check this.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at index ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit wins; grant has at most one bit set.
- Pointer update (clocked): after a grant to unit w, ptr <= (w==NUM_REQ-1) ? 0 : w+1. With no grant, ptr is unchanged.
- Output register, latency 1:
  - The granted unit's tag/data/rd_addr/index are captured at the edge and appear on cdb_* with cdb_valid=1 in the next cycle.
  - Each broadcast lasts exactly one cycle.
  - With no grant: cdb_valid<=0 and cdb_tag/cdb_data/cdb_rd_addr/cdb_src<=0. Payload is zeroed, not held.
- Throughput: one broadcast per cycle sustained. Back-to-back grants to different units and repeat grants to the same unit (sole requester) are both allowed.
- Flush (synchronous, highest priority after reset):
  - grant forced to 0 in the flush cycle.
  - At the edge: cdb_valid<=0, payload <=0, ptr<=0.
  - A broadcast already showing on cdb_* during the flush cycle completes unchanged; only the next cycle is squashed.
- Simultaneous events:
  - flush with req_valid set: no grant; requesters must re-present after flush (normally they are also flushed).
  - Reset mid-burst: outputs clear immediately and asynchronously; ptr restarts at 0.
- Width rules:
  - ptr and cdb_src are $clog2(NUM_REQ) bits.
  - Wrap is explicit compare-to-NUM_REQ-1, not natural overflow, so non-power-of-2 NUM_REQ is correct.
- Fairness: with all units requesting continuously, each unit is granted exactly once every NUM_REQ cycles.

Test Plan:
1. Assert i_rst_n=0 while req_valid=4'b1111 -> grant=0, cdb_valid=0, all cdb_* zero; release reset -> first grant=4'b0001.
2. Single request: req_valid=4'b0010, tag=6'd5, data=32'hDEADBEEF, rd=5'd3 -> grant=4'b0010 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=32'hDEADBEEF, cdb_rd_addr=3, cdb_src=1; cycle after, cdb_valid=0 and payload 0.
3. All four units request continuously from ptr=0 -> grants 0,1,2,3,0,1 on consecutive cycles; cdb_src follows one cycle later; cdb_valid stays high.
4. After a grant to unit 1 (ptr=2), present req_valid=4'b1001 -> unit 3 granted first, then unit 0; no cycle without a grant.
5. Flush cycle with req_valid=4'b0100 and a broadcast on cdb_* -> current broadcast stays intact; grant=0; next cycle cdb_valid=0, ptr=0; then req_valid=4'b0101 -> unit 0 granted.
6. NUM_REQ=3, all requesting -> grants 0,1,2,0 (ptr wraps from 2 to 0, never reaches 3); async reset asserted mid-stream -> cdb_valid drops before the next clock edge.
